// File: rtl/cic_integrator_bank_pkg.sv
// Shared CIC helpers: width arithmetic used when sizing integrator banks.
package cic_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Hogenauer register growth: full-precision width of an N-stage CIC
  // with decimation R and differential delay M.
  function automatic int cic_out_width(input int iw, input int n, input int r, input int m);
    return iw + n * clog2(r * m);
  endfunction

  // Channel-index width; a single-channel bank still carries a 1-bit tag.
  function automatic int chan_width(input int c);
    return (c > 1) ? clog2(c) : 1;
  endfunction

  localparam int CIC_MIN_CHAN_WIDTH = 1;

endpackage

// File: rtl/cic_integrator_stage.sv
// One integrator stage shared by C time-multiplexed channels. Each channel
// owns a wrapping OW-bit accumulator; the stage output is the freshly updated
// accumulator together with the channel tag and valid that produced it.
module cic_integrator_stage
  import cic_pkg::*;
#(
  parameter int OW = 5,
  parameter int C  = 1,
  parameter int CW = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [CW-1:0] i_chan,
  input  logic [OW-1:0] i_data,
  output logic          o_valid,
  output logic [CW-1:0] o_chan,
  output logic [OW-1:0] o_data
);

  logic [OW-1:0] r_acc [C];
  logic          r_valid;
  logic [CW-1:0] r_chan;
  logic [OW-1:0] r_data;
  logic [OW-1:0] w_accSel;
  logic [OW-1:0] w_sum;

  // Pick the accumulator belonging to the incoming sample's channel.
  always_comb begin
    w_accSel = '0;
    for (int c = 0; c < C; c++) begin
      if (i_chan == CW'(c)) begin
        w_accSel = r_acc[c];
      end
    end
  end

  assign w_sum = w_accSel + i_data;

  // Accumulate per channel and register the result; clear zeroes every
  // accumulator but lets a sample already in this stage pass through.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int c = 0; c < C; c++) begin
        r_acc[c] <= '0;
      end
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_chan <= i_chan;
        r_data <= w_sum;
      end
      for (int c = 0; c < C; c++) begin
        if (i_clear) begin
          r_acc[c] <= '0;
        end else if (i_valid && (i_chan == CW'(c))) begin
          r_acc[c] <= w_sum;
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_chan  = r_chan;
  assign o_data  = r_data;

endmodule

// File: rtl/cic_integrator_bank.sv
// N cascaded CIC integrators over C time-multiplexed channels. The top
// sign-extends the input, filters out-of-range channel tags (pulsing o_drop)
// and chains N registered stages, giving an N-cycle latency.
module cic_integrator_bank
  import cic_pkg::*;
#(
  parameter int IW = 2,
  parameter int OW = 5,
  parameter int N  = 3,
  parameter int C  = 1,
  parameter int CW = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_valid,
  input  logic [CW-1:0] i_chan,
  input  logic [IW-1:0] i_data,
  output logic          o_valid,
  output logic [CW-1:0] o_chan,
  output logic [OW-1:0] o_data,
  output logic          o_drop
);

  localparam logic [CW:0] CHAN_LIMIT = (CW + 1)'(C);

  logic          w_chanOk;
  logic          w_accept;
  logic [OW-1:0] w_dataExt;
  logic          w_valid [N+1];
  logic [CW-1:0] w_chan  [N+1];
  logic [OW-1:0] w_data  [N+1];
  logic          r_drop;

  assign w_chanOk  = ({1'b0, i_chan} < CHAN_LIMIT);
  assign w_accept  = i_valid && !i_clear && w_chanOk;
  assign w_dataExt = OW'($signed(i_data));

  assign w_valid[0] = w_accept;
  assign w_chan[0]  = i_chan;
  assign w_data[0]  = w_dataExt;

  // Flag a sample rejected for carrying a channel tag beyond the bank.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= i_valid && !i_clear && !w_chanOk;
    end
  end

  for (genvar k = 0; k < N; k++) begin : gStage
    cic_integrator_stage #(
      .OW (OW),
      .C  (C),
      .CW (CW)
    ) uStage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (i_clear),
      .i_valid (w_valid[k]),
      .i_chan  (w_chan[k]),
      .i_data  (w_data[k]),
      .o_valid (w_valid[k+1]),
      .o_chan  (w_chan[k+1]),
      .o_data  (w_data[k+1])
    );
  end

  assign o_valid = w_valid[N];
  assign o_chan  = w_chan[N];
  assign o_data  = w_data[N];
  assign o_drop  = r_drop;

endmodule

// File: tb/tb_cic_integrator_bank.sv
// Self-checking bench for cic_integrator_bank (IW=4, OW=8, N=3, C=3).
// A reference model applies each accepted sample to N running sums per
// channel and schedules the expected output N cycles later.
module tb_cic_integrator_bank;

  localparam int IW = 4;
  localparam int OW = 8;
  localparam int N  = 3;
  localparam int C  = 3;
  localparam int CW = 2;
  localparam int MASK = (1 << OW) - 1;

  typedef struct {
    int due;
    int chan;
    int data;
  } expEntry_t;

  logic          clk;
  logic          iReset;
  logic          iClear;
  logic          iValid;
  logic [CW-1:0] iChan;
  logic [IW-1:0] iData;
  logic          oValid;
  logic [CW-1:0] oChan;
  logic [OW-1:0] oData;
  logic          oDrop;

  int errCount;
  int checkCount;
  int cyc;

  // Reference model state.
  int        modelAcc [N][C];
  expEntry_t expQueue [$];
  int        lastChan;
  int        lastData;
  int        expDrop;
  bit        capture;
  int        capQueue [$];

  cic_integrator_bank #(
    .IW (IW),
    .OW (OW),
    .N  (N),
    .C  (C),
    .CW (CW)
  ) dut (
    .i_clk   (clk),
    .i_reset (iReset),
    .i_clear (iClear),
    .i_valid (iValid),
    .i_chan  (iChan),
    .i_data  (iData),
    .o_valid (oValid),
    .o_chan  (oChan),
    .o_data  (oData),
    .o_drop  (oDrop)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < N; k++)
      for (int c = 0; c < C; c++)
        modelAcc[k][c] = 0;
    expQueue.delete();
    lastChan = 0;
    lastData = 0;
    expDrop  = 0;
  endtask

  // One clock cycle: check what the DUT shows now, then drive the next inputs
  // and advance the model with them.
  task automatic applyStimulus(input logic v, input int ch, input int d,
                               input logic clr, input logic rst);
    int        expValid;
    int        x;
    expEntry_t e;
    @(negedge clk);
    expValid = 0;
    if (expQueue.size() > 0 && expQueue[0].due == cyc) begin
      e        = expQueue.pop_front();
      expValid = 1;
      lastChan = e.chan;
      lastData = e.data;
    end
    checkOutput("o_valid", 32'(oValid), 32'(expValid));
    checkOutput("o_chan",  32'(oChan),  32'(lastChan));
    checkOutput("o_data",  32'(oData),  32'(lastData));
    checkOutput("o_drop",  32'(oDrop),  32'(expDrop));
    if (capture && oValid === 1'b1) capQueue.push_back(int'(oData));

    iValid = v;
    iChan  = CW'(ch);
    iData  = IW'(d);
    iClear = clr;
    iReset = rst;

    expDrop = 0;
    if (rst) begin
      modelReset();
    end else if (clr) begin
      for (int k = 0; k < N; k++)
        for (int c = 0; c < C; c++)
          modelAcc[k][c] = 0;
    end else if (v) begin
      if (ch >= C) begin
        expDrop = 1;
      end else begin
        x = (d & ((1 << IW) - 1));
        if (x >= (1 << (IW - 1))) x = x - (1 << IW);
        for (int k = 0; k < N; k++) begin
          modelAcc[k][ch] = (modelAcc[k][ch] + x) & MASK;
          x = modelAcc[k][ch];
        end
        expQueue.push_back('{due: cyc + N, chan: ch, data: x});
      end
    end
    cyc++;
  endtask

  task automatic idle(input int count);
    for (int i = 0; i < count; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic runImpulse();
    int golden [5];
    golden = '{1, 3, 6, 10, 15};
    capQueue.delete();
    capture = 1'b1;
    applyStimulus(1'b1, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    idle(N + 1);
    capture = 1'b0;
    checkOutput("impulse_len", 32'(capQueue.size()), 32'd5);
    for (int i = 0; i < 5 && i < capQueue.size(); i++)
      checkOutput("impulse_val", 32'(capQueue[i]), 32'(golden[i]));
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    cyc        = 0;
    capture    = 1'b0;
    iReset     = 1'b1;
    iClear     = 1'b0;
    iValid     = 1'b0;
    iChan      = '0;
    iData      = '0;
    modelReset();
    @(posedge clk);

    // Reset held a few cycles: everything must read zero.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

    // Impulse response from a clean start.
    runImpulse();

    // Reset in the middle of an impulse, then restart from scratch.
    applyStimulus(1'b1, 0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    runImpulse();

    // Interleaved channels with opposite signs.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 0, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1, -1, 1'b0, 1'b0);
    end
    // Gaps between samples on channel 2.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2, 2, 1'b0, 1'b0);
      applyStimulus(1'b0, 2, 7, 1'b0, 1'b0);
    end
    idle(N + 1);

    // Clear with a sample in the same cycle: sample discarded, no drop.
    applyStimulus(1'b1, 0, 7, 1'b1, 1'b0);
    applyStimulus(1'b1, 0, 1, 1'b0, 1'b0);
    idle(N + 1);

    // Out-of-range channel, then a normal channel-0 sample.
    applyStimulus(1'b1, 3, 5, 1'b0, 1'b0);
    applyStimulus(1'b1, 0, 1, 1'b0, 1'b0);
    idle(N + 1);

    // Long positive run so stage sums wrap modulo 2^OW.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1, 7, 1'b0, 1'b0);
    idle(N + 1);

    // Randomised traffic; clear is only issued once the pipeline has drained.
    for (int i = 0; i < 800; i++) begin
      logic v, clr, rst;
      int   r;
      r   = int'($urandom_range(0, 99));
      rst = (r < 2);
      clr = (r >= 2 && r < 6 && expQueue.size() == 0);
      v   = ($urandom_range(0, 9) < 7);
      applyStimulus(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), clr, rst);
    end
    idle(N + 2);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
